// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: highest-index-first over a rotating mask, grant held
// until done/abort, with a watchdog that force-releases overlong grants.
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = $clog2(NUM_MASTERS),
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   done,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [ID_WIDTH-1:0]    gnt_id,
  output logic                   gnt_valid,
  output logic                   timeout_err,
  output logic                   state_dbg
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic [ID_WIDTH-1:0]    id_d;
  logic                   terr_d;

  logic [NUM_MASTERS-1:0] below_last;
  logic [NUM_MASTERS-1:0] masked;
  logic [ID_WIDTH-1:0]    win;
  logic                   expire;
  logic                   release_now;
  logic                   load;

  function automatic logic [ID_WIDTH-1:0] highest_set(input logic [NUM_MASTERS-1:0] v);
    logic [ID_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (v[i]) r = ID_WIDTH'(i);
    end
    return r;
  endfunction

  // Masking everything at or above the last winner rotates priority downward.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      below_last[i] = (i < int'(last_q));
    end
    masked = req & below_last;
    win    = (|masked) ? highest_set(masked) : highest_set(req);
  end

  assign expire      = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign release_now = done | ~req[gnt_id] | expire;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) load = 1'b1;
      end
      OWNED: begin
        if (release_now) begin
          // An abort or completion on the expiry edge is an ordinary release.
          terr_d = expire & ~done & req[gnt_id];
          if (|req) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d   = OWNED;
      gnt_d     = '0;
      gnt_d[win] = 1'b1;
      id_d      = win;
      last_d    = win;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt         <= gnt_d;
      gnt_id      <= id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      timeout_err <= terr_d;
    end
  end

  assign gnt_valid = (state_q == OWNED);
  assign state_dbg = (state_q == OWNED);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vectors, a cycle-level behavioural model feeding
// an expected queue, and literal expectations at key points of each scenario.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         timeout_err;
  logic         state_dbg;

  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: owner (-1 = none), last winner, cycles the grant has been held.
  int   m_owner = -1;
  int   m_last  = 0;
  int   m_held  = 0;
  bit   m_terr  = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic int pick(input logic [N-1:0] r, input int last);
    int w;
    w = -1;
    for (int i = N - 1; i >= 0; i--)
      if (w < 0 && r[i] && i < last) w = i;
    for (int i = N - 1; i >= 0; i--)
      if (w < 0 && r[i]) w = i;
    return w;
  endfunction

  function automatic logic [W-1:0] exp_word();
    logic [N-1:0] g;
    logic [1:0]   id;
    g  = '0;
    id = '0;
    if (m_owner >= 0) begin
      g  = N'(1 << m_owner);
      id = 2'(m_owner);
    end
    return {m_terr, (m_owner >= 0), id, g};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_owner = -1;
      m_last  = 0;
      m_held  = 0;
      m_terr  = 1'b0;
      exp_q.delete();
      exp_q.push_back(exp_word());
    end else begin
      int w;
      bit rel;
      bit wd;
      m_terr = 1'b0;
      rel    = 1'b1;
      if (m_owner >= 0) begin
        wd     = (TO != 0) && (m_held + 1 == TO);
        rel    = done || !req[m_owner] || wd;
        m_terr = wd && !done && req[m_owner];
      end
      if (rel) begin
        w = pick(req, m_last);
        m_held = 0;
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
      exp_q.push_back(exp_word());
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("model_gnt", gnt, e[3:0]);
      chk("model_gnt_id", gnt_id, e[5:4]);
      chk("model_gnt_valid", gnt_valid, e[6]);
      chk("model_timeout_err", timeout_err, e[7]);
      chk("model_state_dbg", state_dbg, e[6]);
    end
  end

  int rot[5] = '{3, 2, 1, 0, 3};

  initial begin
    resetn = 1'b0;
    req    = '0;
    done   = 1'b0;
    tick(2);
    chk("reset_gnt", gnt, 0);
    chk("reset_gnt_id", gnt_id, 0);
    chk("reset_valid", gnt_valid, 0);
    chk("reset_terr", timeout_err, 0);
    resetn = 1'b1;
    tick(1);
    chk("idle_no_req", gnt_valid, 0);

    // Rotation with done every third cycle
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      done = 1'b0;
      chk("rot_id", gnt_id, rot[k]);
      chk("rot_valid", gnt_valid, 1);
      if (k < 4) begin
        tick(2);
        done = 1'b1;
      end
    end

    // Handover 3 -> 2 (abort), then 2 -> 0 on done
    req = 4'b0101;
    tick(1);
    chk("hand_gnt2", gnt, 4'b0100);
    chk("hand_id2", gnt_id, 2);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("hand_gnt0", gnt, 4'b0001);
    chk("hand_valid", gnt_valid, 1);

    // Abort to idle, done ignored while idle
    req = 4'b0010;
    tick(1);
    chk("abort_pre_id", gnt_id, 1);
    req = 4'b0000;
    tick(1);
    chk("abort_valid", gnt_valid, 0);
    chk("abort_gnt", gnt, 0);
    done = 1'b1;
    tick(2);
    chk("idle_done_valid", gnt_valid, 0);
    chk("idle_done_gnt", gnt, 0);
    done = 1'b0;
    req  = 4'b0010;
    tick(1);
    chk("regrant_id", gnt_id, 1);
    chk("regrant_gnt", gnt, 4'b0010);

    // Watchdog: master 3 held 8 cycles without done
    req = 4'b1000;
    tick(1);
    chk("wd_owner3", gnt_id, 3);
    req = 4'b1001;
    tick(7);
    chk("wd_cycle8_id", gnt_id, 3);
    chk("wd_cycle8_terr", timeout_err, 0);
    tick(1);
    chk("wd_terr", timeout_err, 1);
    chk("wd_next_id", gnt_id, 0);
    chk("wd_next_valid", gnt_valid, 1);
    tick(1);
    chk("wd_terr_pulse", timeout_err, 0);

    // done on the expiry edge of master 0
    tick(6);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("sim_terr", timeout_err, 0);
    chk("sim_id", gnt_id, 3);

    // Asynchronous reset while master 2 owns the bus
    req = 4'b0100;
    tick(1);
    chk("rst_pre_gnt", gnt, 4'b0100);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_gnt", gnt, 0);
    chk("rst_async_id", gnt_id, 0);
    chk("rst_async_valid", gnt_valid, 0);
    req = 4'b1010;
    tick(1);
    chk("rst_hold_valid", gnt_valid, 0);
    resetn = 1'b1;
    tick(1);
    chk("rst_after_gnt", gnt, 4'b1000);
    chk("rst_after_id", gnt_id, 3);

    req = '0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single memory/bus port of the core between up to `NUM_MASTERS` requesters (fetch, load/store, DMA, debug). Each cycle it selects a winner with a highest-index-first priority encode over a rotating mask, holds the grant until the granted transfer completes, and force-releases grants that exceed a watchdog limit. Its outputs drive the bus multiplexer select and the per-master grant lines.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..16.
- `ID_WIDTH`, clogb2(NUM_MASTERS-1): width of the encoded grant index.
- `TIMEOUT`, 255: max cycles a grant may be held without `done`; 0 disables the watchdog.
- `clk`  in  1  single clock, all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_MASTERS  request per master, level, held until granted and done.
- `done`  in  1  slave completion pulse for the currently granted transfer.
- `gnt`  out  NUM_MASTERS  one-hot grant, registered.
- `gnt_id`  out  ID_WIDTH  index of the granted master, registered.
- `gnt_valid`  out  1  a grant is active.
- `timeout_err`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- Two states: IDLE (no grant), OWNED (grant held by `gnt_id`).
- Priority: highest index wins. Masked request = `req` with bits at index >= last winner cleared. If masked request is non-zero, the winner is its highest set bit, otherwise the highest set bit of `req`. Last winner resets to 0, so the first arbitration after reset is pure highest-index.
- IDLE: if `req` != 0, load winner into `gnt`/`gnt_id`, set `gnt_valid`, update last winner, go to OWNED. Otherwise stay; outputs stay zero.
- OWNED, release condition: `done`=1, or `req[gnt_id]`=0 (abort), or watchdog expiry.
- On release with `req` (excluding nothing: the releasing master may re-win only if no other master is eligible) != 0: re-arbitrate in the same edge. Stay in OWNED with the new winner, with no dead cycle.
- On release with `req`=0: go to IDLE and clear `gnt`, `gnt_id`, `gnt_valid`.
- Watchdog: counter clears on every grant load and increments each OWNED cycle without release. When it reaches `TIMEOUT`-1, release on that edge and pulse `timeout_err` for one cycle. The counter saturates and never wraps. It is inactive when `TIMEOUT`=0.
- `done` in IDLE is ignored.
- `done` and timeout on the same edge count as a normal release with no `timeout_err`.
- Invariants: `gnt` is always one-hot or zero. `gnt_valid`=|`gnt`. `gnt`[`gnt_id`]=`gnt_valid`.

## Timing
- Reset (`resetn`=0, asynchronous, any time including mid-transfer): `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout_err`=0, last winner=0, counter=0, state IDLE. Outputs are usable on the first edge after deassertion.
- Grant latency: `req` sampled at edge t appears as `gnt` after edge t; the grant is visible in cycle t+1.
- Handover: `done` sampled at edge t gives the next master its grant from cycle t+1; the bus is never idle between back-to-back owners.
- Abort: `req[gnt_id]` falling at edge t removes the grant after edge t.
- Worst-case wait for any continuously requesting master: (NUM_MASTERS-1) grants.

## Test plan
- Reset: assert `resetn`=0 while OWNED with `gnt`=4'b0100 -> all outputs 0 immediately; after release with `req`=4'b1010, `gnt`=4'b1000 and `gnt_id`=3 one edge later.
- Rotation: `req`=4'b1111 held, `done` pulsed every 3 cycles -> grant order 3,2,1,0,3, with `gnt_valid` continuously 1.
- Back-to-back handover: owner 2 gets `done` while `req`=4'b0101 -> next cycle `gnt`=4'b0001 (mask excludes index >= 2), with no idle cycle.
- Abort and idle: owner 1 drops `req` with no other requests -> next cycle `gnt_valid`=0 and `gnt`=0; later `req`=4'b0010 -> `gnt_id`=1.
- Watchdog: `TIMEOUT`=8, master 3 granted and `done` held at 0 -> release after 8 OWNED cycles, one-cycle `timeout_err`, grant passes to the next eligible requester.
- Simultaneous events: `done` on the same edge as watchdog expiry -> `timeout_err` stays 0. `done` in IDLE -> no state change.
